// File: rtl/axi_simple_master.sv
// axi_simple_master: single-outstanding AXI4 initiator.
//
// Accepts one write or read command at a time on a valid/ready command port and runs
// the complete AW/W/B or AR/R exchange for it. When the exchange ends it pulses DONE
// for one cycle and updates DONE_RESP, DONE_ERR and DONE_SUM in the same cycle. These
// three outputs then hold their values until the next completion.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   CMD_*                    command port (VALID/READY, WRITE, ID, ADDR, LEN=beats-1, DATA seed)
//   DONE, DONE_RESP/ERR/SUM  completion pulse, worst response, protocol error, read-data sum
//   AW*, W*, B*              AXI4 write address, write data and write response channels
//   AR*, R*                  AXI4 read address and read data channels
module axi_simple_master #(
    parameter int unsigned WIDTH_SID = 8,
    parameter int unsigned WIDTH_AD  = 32,
    parameter int unsigned WIDTH_DA  = 32,
    parameter int unsigned WIDTH_DS  = WIDTH_DA / 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    // Command / completion
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic                 CMD_WRITE,
    input  logic [WIDTH_SID-1:0] CMD_ID,
    input  logic [WIDTH_AD-1:0]  CMD_ADDR,
    input  logic [7:0]           CMD_LEN,
    input  logic [WIDTH_DA-1:0]  CMD_DATA,
    output logic                 DONE,
    output logic [1:0]           DONE_RESP,
    output logic                 DONE_ERR,
    output logic [WIDTH_DA-1:0]  DONE_SUM,
    // Write address
    output logic [WIDTH_SID-1:0] AWID,
    output logic [WIDTH_AD-1:0]  AWADDR,
    output logic [7:0]           AWLEN,
    output logic [2:0]           AWSIZE,
    output logic [1:0]           AWBURST,
    output logic                 AWVALID,
    input  logic                 AWREADY,
    // Write data
    output logic [WIDTH_SID-1:0] WID,
    output logic [WIDTH_DA-1:0]  WDATA,
    output logic [WIDTH_DS-1:0]  WSTRB,
    output logic                 WLAST,
    output logic                 WVALID,
    input  logic                 WREADY,
    // Write response
    input  logic [WIDTH_SID-1:0] BID,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    output logic                 BREADY,
    // Read address
    output logic [WIDTH_SID-1:0] ARID,
    output logic [WIDTH_AD-1:0]  ARADDR,
    output logic [7:0]           ARLEN,
    output logic [2:0]           ARSIZE,
    output logic [1:0]           ARBURST,
    output logic                 ARVALID,
    input  logic                 ARREADY,
    // Read data
    input  logic [WIDTH_SID-1:0] RID,
    input  logic [WIDTH_DA-1:0]  RDATA,
    input  logic [1:0]           RRESP,
    input  logic                 RLAST,
    input  logic                 RVALID,
    output logic                 RREADY
);

    // Full-width beats only, so the size code is log2 of the bytes per beat.
    localparam logic [2:0] AxSize = 3'($clog2(WIDTH_DS));

    typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR, StFin} state_e;

    state_e state_q, state_d;

    logic [WIDTH_SID-1:0] id_q, id_d;
    logic [WIDTH_AD-1:0]  addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [WIDTH_DA-1:0]  seed_q, seed_d;
    logic                 write_q, write_d;
    logic [8:0]           beat_q, beat_d;
    logic [WIDTH_DA-1:0]  wdata_q, wdata_d;
    logic                 wlast_q, wlast_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic [1:0]           resp_q, resp_d;
    logic                 err_q, err_d;
    logic [WIDTH_DA-1:0]  sum_q, sum_d;
    logic                 done_q, done_d;
    logic [1:0]           done_resp_q, done_resp_d;
    logic                 done_err_q, done_err_d;
    logic [WIDTH_DA-1:0]  done_sum_q, done_sum_d;

    logic       cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic       beat_is_last, r_end;
    logic [8:0] beat_inc;

    assign CMD_READY    = (state_q == StIdle);
    assign cmd_fire     = CMD_VALID && CMD_READY;
    assign aw_fire      = awvalid_q && AWREADY;
    assign w_fire       = wvalid_q && WREADY;
    assign b_fire       = bready_q && BVALID;
    assign ar_fire      = arvalid_q && ARREADY;
    assign r_fire       = rready_q && RVALID;
    assign beat_inc     = beat_q + 9'd1;
    assign beat_is_last = (beat_q == {1'b0, len_q});
    // A read ends on whichever comes first: the responder's RLAST or our own beat count.
    assign r_end        = RLAST || beat_is_last;

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_fire) state_d = CMD_WRITE ? StAw : StAr;
            StAw:    if (aw_fire) state_d = StW;
            StW:     if (w_fire && wlast_q) state_d = StB;
            StB:     if (b_fire) state_d = StFin;
            StAr:    if (ar_fire) state_d = StR;
            StR:     if (r_fire && r_end) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        seed_d      = seed_q;
        write_d     = write_q;
        beat_d      = beat_q;
        wdata_d     = wdata_q;
        wlast_d     = wlast_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        resp_d      = resp_q;
        err_d       = err_q;
        sum_d       = sum_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        done_err_d  = done_err_q;
        done_sum_d  = done_sum_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    id_d      = CMD_ID;
                    addr_d    = CMD_ADDR;
                    len_d     = CMD_LEN;
                    seed_d    = CMD_DATA;
                    write_d   = CMD_WRITE;
                    awvalid_d = CMD_WRITE;
                    arvalid_d = !CMD_WRITE;
                end
            end
            StAw: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = seed_q;
                    wlast_d   = (len_q == 8'd0);
                    beat_d    = 9'd0;
                end
            end
            StW: begin
                if (w_fire) begin
                    beat_d  = beat_inc;
                    // Data pattern is seed + beat index, wrapping at the data width.
                    wdata_d = seed_q + WIDTH_DA'(beat_inc);
                    wlast_d = (beat_inc == {1'b0, len_q});
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                    end
                end
            end
            StB: begin
                if (b_fire) begin
                    bready_d = 1'b0;
                    resp_d   = BRESP;
                    err_d    = (BID != id_q);
                end
            end
            StAr: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    beat_d    = 9'd0;
                    sum_d     = '0;
                    resp_d    = 2'b00;
                    err_d     = 1'b0;
                end
            end
            StR: begin
                if (r_fire) begin
                    sum_d  = sum_q + RDATA;
                    // Numeric max: DECERR (2'b11) is treated as the worst outcome.
                    resp_d = (RRESP > resp_q) ? RRESP : resp_q;
                    err_d  = err_q | (RID != id_q) | (RLAST ^ beat_is_last);
                    beat_d = beat_inc;
                    if (r_end) rready_d = 1'b0;
                end
            end
            StFin: begin
                done_d      = 1'b1;
                done_resp_d = resp_q;
                done_err_d  = err_q;
                done_sum_d  = write_q ? '0 : sum_q;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            seed_q      <= '0;
            write_q     <= 1'b0;
            beat_q      <= '0;
            wdata_q     <= '0;
            wlast_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            resp_q      <= 2'b00;
            err_q       <= 1'b0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            done_err_q  <= 1'b0;
            done_sum_q  <= '0;
        end else begin
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            write_q     <= write_d;
            beat_q      <= beat_d;
            wdata_q     <= wdata_d;
            wlast_q     <= wlast_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            done_err_q  <= done_err_d;
            done_sum_q  <= done_sum_d;
        end
    end

    assign DONE      = done_q;
    assign DONE_RESP = done_resp_q;
    assign DONE_ERR  = done_err_q;
    assign DONE_SUM  = done_sum_q;

    assign AWID    = id_q;
    assign AWADDR  = addr_q;
    assign AWLEN   = len_q;
    assign AWSIZE  = AxSize;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;

    assign WID     = id_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = '1;
    assign WLAST   = wlast_q;
    assign WVALID  = wvalid_q;

    assign BREADY  = bready_q;

    assign ARID    = id_q;
    assign ARADDR  = addr_q;
    assign ARLEN   = len_q;
    assign ARSIZE  = AxSize;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;

    assign RREADY  = rready_q;

endmodule
